// File: rtl/alu_result_collector.sv
// -----------------------------------------------------------------------------
// alu_result_collector
//
// Return path of the ALU. The dispatcher issues one opcode at a time. This block
// waits for the matching functional unit to pulse its done bit, turns the done
// vector back into a 3-bit opcode, compares it with the opcode that was issued,
// and presents one tagged result downstream through a valid/ready handshake.
//
// Unit mapping (done bit index == opcode):
//   0 add, 1 sub, 2 mul, 3 shift, 4 and, 5 or, 6 xor, 7 div
//
// Parameters
//   WIDTH    result width of every functional unit
//   TIMEOUT  cycles to wait for a done before aborting; 0 disables the timeout
//
// Ports
//   clk           in   single clock, rising edge
//   rst           in   synchronous active-high reset
//   issue_valid   in   dispatcher presents an opcode
//   issue_opcode  in   opcode just dispatched
//   issue_ready   out  collector can accept an issue
//   unit_done     in   per-unit done pulses, index = opcode
//   unit_result   in   per-unit results, slice i = [i*WIDTH +: WIDTH]
//   res_valid     out  result/tag/err held stable until accepted
//   res_ready     in   downstream accepts the result
//   res_data      out  captured result
//   res_opcode    out  opcode encoded from unit_done
//   res_err       out  00 ok, 01 mismatch, 10 multi-hot, 11 timeout
//   spurious      out  sticky: unit_done seen while not waiting for one
// -----------------------------------------------------------------------------
module alu_result_collector #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               issue_valid,
    input  logic [2:0]         issue_opcode,
    output logic               issue_ready,
    input  logic [7:0]         unit_done,
    input  logic [8*WIDTH-1:0] unit_result,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [WIDTH-1:0]   res_data,
    output logic [2:0]         res_opcode,
    output logic [1:0]         res_err,
    output logic               spurious
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISMATCH = 2'b01;
    localparam logic [1:0] ERR_MULTI    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    // Timer is wide enough to reach TIMEOUT-1 and then sit saturated.
    localparam int             TW   = $clog2(TIMEOUT + 2) + 1;
    localparam logic [TW-1:0]  TMAX = '1;
    localparam logic [TW-1:0]  TLIM = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    // Lowest set bit wins when more than one unit reports done.
    function automatic logic [2:0] lowest_idx(input logic [7:0] v);
        logic [2:0] r;
        casez (v)
            8'b????_???1: r = 3'd0;
            8'b????_??10: r = 3'd1;
            8'b????_?100: r = 3'd2;
            8'b????_1000: r = 3'd3;
            8'b???1_0000: r = 3'd4;
            8'b??10_0000: r = 3'd5;
            8'b?100_0000: r = 3'd6;
            8'b1000_0000: r = 3'd7;
            default:      r = 3'd0;
        endcase
        return r;
    endfunction

    // True when two or more bits are set.
    function automatic logic is_multi_hot(input logic [7:0] v);
        return (v & (v - 8'd1)) != 8'd0;
    endfunction

    state_e           state_q, state_d;
    logic [2:0]       exp_op_q, exp_op_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [TW-1:0]    timer_inc;
    logic             issue_ready_q, issue_ready_d;
    logic             res_valid_q, res_valid_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic [2:0]       res_opcode_q, res_opcode_d;
    logic [1:0]       res_err_q, res_err_d;
    logic             spurious_q, spurious_d;
    logic [2:0]       hit_idx;
    logic             timeout_hit;

    // Next-state and next-output logic for the IDLE/WAIT/HOLD sequence.
    always_comb begin
        state_d      = state_q;
        exp_op_d     = exp_op_q;
        timer_d      = timer_q;
        res_valid_d  = res_valid_q;
        res_data_d   = res_data_q;
        res_opcode_d = res_opcode_q;
        res_err_d    = res_err_q;
        hit_idx      = lowest_idx(unit_done);
        timer_inc    = (timer_q == TMAX) ? timer_q : (timer_q + {{(TW-1){1'b0}}, 1'b1});
        // timer_inc counts the current WAIT cycle, so the abort fires in
        // cycle TIMEOUT-1 after the issue and res_valid shows in cycle TIMEOUT.
        timeout_hit  = (TIMEOUT != 0) && (timer_inc >= TLIM);

        case (state_q)
            ST_IDLE: begin
                if (issue_valid && issue_ready_q) begin
                    exp_op_d = issue_opcode;
                    timer_d  = '0;
                    state_d  = ST_WAIT;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (unit_done != 8'd0) begin
                    res_data_d   = unit_result[int'(hit_idx) * WIDTH +: WIDTH];
                    res_opcode_d = hit_idx;
                    if (is_multi_hot(unit_done)) begin
                        res_err_d = ERR_MULTI;
                    end else if (hit_idx == exp_op_q) begin
                        res_err_d = ERR_OK;
                    end else begin
                        res_err_d = ERR_MISMATCH;
                    end
                    res_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end else begin
                    timer_d = timer_inc;
                    if (timeout_hit) begin
                        res_data_d   = '0;
                        res_opcode_d = exp_op_q;
                        res_err_d    = ERR_TIMEOUT;
                        res_valid_d  = 1'b1;
                        state_d      = ST_HOLD;
                    end else begin
                        state_d      = ST_WAIT;
                    end
                end
            end
            ST_HOLD: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d     = ST_HOLD;
                end
            end
            default: begin
                res_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase

        // Ready tracks the state being entered, so it is a clean register output.
        issue_ready_d = (state_d == ST_IDLE);
        spurious_d    = spurious_q | ((state_q != ST_WAIT) && (unit_done != 8'd0));
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            exp_op_q      <= 3'd0;
            timer_q       <= '0;
            issue_ready_q <= 1'b0;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
            res_opcode_q  <= 3'd0;
            res_err_q     <= 2'd0;
            spurious_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            exp_op_q      <= exp_op_d;
            timer_q       <= timer_d;
            issue_ready_q <= issue_ready_d;
            res_valid_q   <= res_valid_d;
            res_data_q    <= res_data_d;
            res_opcode_q  <= res_opcode_d;
            res_err_q     <= res_err_d;
            spurious_q    <= spurious_d;
        end
    end

    assign issue_ready = issue_ready_q;
    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign res_opcode  = res_opcode_q;
    assign res_err     = res_err_q;
    assign spurious    = spurious_q;

endmodule

// File: tb/tb_alu_result_collector.sv
// -----------------------------------------------------------------------------
// tb_alu_result_collector
//
// Self-checking bench for alu_result_collector (WIDTH=32, TIMEOUT=64).
// Each operation is described by: issued opcode, done vector, cycle offset of
// the done (1 = the cycle right after the issue handshake), hold length under
// backpressure, and whether a stray done is poked during the hold. Expected
// results come from a small reference model of the collector's rules.
// -----------------------------------------------------------------------------
module tb_alu_result_collector;

    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 64;

    logic               clk;
    logic               rst;
    logic               issue_valid;
    logic [2:0]         issue_opcode;
    logic               issue_ready;
    logic [7:0]         unit_done;
    logic [8*WIDTH-1:0] unit_result;
    logic               res_valid;
    logic               res_ready;
    logic [WIDTH-1:0]   res_data;
    logic [2:0]         res_opcode;
    logic [1:0]         res_err;
    logic               spurious;

    int          n_total;
    int          n_bad;
    bit          spur_exp;
    logic [31:0] slice_val [8];

    alu_result_collector #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .issue_opcode (issue_opcode),
        .issue_ready  (issue_ready),
        .unit_done    (unit_done),
        .unit_result  (unit_result),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_opcode   (res_opcode),
        .res_err      (res_err),
        .spurious     (spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_results(input bit rnd);
        for (int i = 0; i < 8; i++) begin
            if (rnd) slice_val[i] = $urandom;
            unit_result[i*WIDTH +: WIDTH] = slice_val[i];
        end
    endtask

    // Reference model: what the collector should present for this operation.
    task automatic predict(input logic [2:0] op, input logic [7:0] vec, input bit took_done,
                           output logic [31:0] e_data, output logic [2:0] e_op,
                           output logic [1:0] e_err);
        int first;
        int ones;
        if (!took_done) begin
            e_data = 32'd0;
            e_op   = op;
            e_err  = 2'b11;
        end else begin
            first = -1;
            ones  = 0;
            for (int i = 0; i < 8; i++) begin
                if (vec[i]) begin
                    ones++;
                    if (first < 0) first = i;
                end
            end
            e_data = slice_val[first];
            e_op   = 3'(first);
            if (ones > 1)          e_err = 2'b10;
            else if (first == op)  e_err = 2'b00;
            else                   e_err = 2'b01;
        end
    endtask

    // One complete operation from issue handshake to result acceptance.
    task automatic run_op(input logic [2:0] op, input logic [7:0] vec, input int d,
                          input int hold, input bit poke_hold);
        bit          took_done;
        int          fire_c;
        logic [31:0] e_data;
        logic [2:0]  e_op;
        logic [1:0]  e_err;

        took_done = (vec != 8'd0) && (d >= 1) && (d <= TIMEOUT - 1);
        fire_c    = took_done ? d : (TIMEOUT - 1);

        check_val("issue_ready_idle", 64'(issue_ready), 64'd1);
        issue_valid  = 1'b1;
        issue_opcode = op;
        tick();
        issue_valid  = 1'b0;
        check_val("issue_ready_wait", 64'(issue_ready), 64'd0);

        for (int c = 1; c <= fire_c; c++) begin
            check_val("valid_early", 64'(res_valid), 64'd0);
            unit_done = (took_done && (c == d)) ? vec : 8'd0;
            tick();
        end
        unit_done = 8'd0;

        predict(op, vec, took_done, e_data, e_op, e_err);
        check_val("res_valid", 64'(res_valid), 64'd1);
        check_val("res_data", 64'(res_data), 64'(e_data));
        check_val("res_opcode", 64'(res_opcode), 64'(e_op));
        check_val("res_err", 64'(res_err), 64'(e_err));

        for (int h = 0; h < hold; h++) begin
            if (poke_hold && (h == 0)) begin
                unit_done = 8'h08;
                spur_exp  = 1'b1;
            end
            tick();
            unit_done = 8'd0;
            check_val("hold_valid", 64'(res_valid), 64'd1);
            check_val("hold_data", 64'(res_data), 64'(e_data));
            check_val("hold_tag", 64'({res_opcode, res_err}), 64'({e_op, e_err}));
        end

        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check_val("valid_after_accept", 64'(res_valid), 64'd0);
        check_val("ready_after_accept", 64'(issue_ready), 64'd1);
        check_val("spurious", 64'(spurious), 64'(spur_exp));
    endtask

    task automatic check_all_zero(input string tag);
        check_val(tag, 64'({issue_ready, res_valid, res_data, res_opcode, res_err, spurious}), 64'd0);
    endtask

    initial begin
        logic [7:0] vec;
        logic [2:0] op;
        int         kind;
        int         a;
        int         b;
        int         d;

        n_total      = 0;
        n_bad        = 0;
        spur_exp     = 1'b0;
        rst          = 1'b1;
        issue_valid  = 1'b0;
        issue_opcode = 3'd0;
        unit_done    = 8'd0;
        res_ready    = 1'b0;
        for (int i = 0; i < 8; i++) slice_val[i] = 32'h1000_0000 + 32'(i);
        set_results(1'b0);

        // Reset state and release timing.
        tick();
        tick();
        check_all_zero("reset_outputs");
        rst = 1'b0;
        check_val("ready_during_release", 64'(issue_ready), 64'd0);
        tick();
        check_val("ready_after_release", 64'(issue_ready), 64'd1);

        // Matching single done two cycles after issue, held 5 cycles.
        slice_val[2] = 32'h0000_0015;
        set_results(1'b0);
        run_op(3'd2, 8'h04, 2, 5, 1'b0);

        // Wrong unit answers.
        slice_val[6] = 32'h0000_00FF;
        set_results(1'b0);
        run_op(3'd1, 8'h40, 3, 1, 1'b0);

        // Multi-hot: lowest index (4) wins, error is multi-hot.
        run_op(3'd0, 8'h90, 1, 0, 1'b0);

        // Timeout, then done exactly in the last cycle before the timeout.
        run_op(3'd7, 8'h00, 100, 2, 1'b0);
        run_op(3'd7, 8'h80, TIMEOUT - 1, 0, 1'b0);
        // Done one cycle too late is never seen: timeout reported.
        run_op(3'd5, 8'h20, TIMEOUT, 0, 1'b0);

        // Reset while waiting drops the op; a fresh op then works.
        issue_valid  = 1'b1;
        issue_opcode = 3'd3;
        tick();
        issue_valid  = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check_all_zero("reset_in_wait");
        rst = 1'b0;
        tick();
        run_op(3'd3, 8'h08, 2, 1, 1'b0);

        // Stray done while idle, then while holding a result.
        unit_done = 8'h08;
        tick();
        unit_done = 8'd0;
        spur_exp  = 1'b1;
        check_val("spurious_idle", 64'(spurious), 64'd1);
        run_op(3'd4, 8'h10, 1, 3, 1'b1);

        // Randomized operations.
        for (int n = 0; n < 60; n++) begin
            set_results(1'b1);
            op   = 3'($urandom_range(0, 7));
            kind = $urandom_range(0, 7);
            d    = $urandom_range(1, 6);
            case (kind)
                0, 1, 2: vec = 8'd1 << op;
                3, 4: begin
                    a   = (int'(op) + $urandom_range(1, 7)) % 8;
                    vec = 8'd1 << a;
                end
                5, 6: begin
                    a   = $urandom_range(0, 7);
                    b   = (a + $urandom_range(1, 7)) % 8;
                    vec = (8'd1 << a) | (8'd1 << b) | 8'($urandom_range(0, 255));
                end
                default: begin
                    vec = 8'd0;
                    d   = 100;
                end
            endcase
            run_op(op, vec, d, $urandom_range(0, 3), ($urandom_range(0, 5) == 0));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
